// File: rtl/main_core_selftest_seq_pkg.sv
// Shared types for the main_core self-test sequencer: script op codes, fail codes, FSM states.
// Script entry layout is {op[OP_W-1:0], payload[PW-1:0]} with PW = pw_of(DATA_W, CMD_W).
package main_core_selftest_seq_pkg;

  localparam int OP_W   = 3;
  localparam int WAIT_W = 16;

  typedef enum logic [2:0] {
    OP_END   = 3'd0,
    OP_CMD   = 3'd1,
    OP_SEND  = 3'd2,
    OP_RECV  = 3'd3,
    OP_DRAIN = 3'd4,
    OP_WAIT  = 3'd5,
    OP_RST   = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISMATCH = 2'd1,
    FC_TIMEOUT  = 2'd2,
    FC_OVERRUN  = 2'd3
  } fail_code_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_e;

  function automatic int pw_of(input int data_w, input int cmd_w);
    return (data_w > cmd_w) ? data_w : cmd_w;
  endfunction

endpackage

// File: rtl/main_core_selftest_seq_if.sv
// main_core cmd/in/out handshake bundle plus the core reset pulse.
// master = sequencer side, slave = core side.
interface main_core_selftest_seq_if #(
  parameter int DATA_W = 64,
  parameter int CMD_W  = 16
) ();
  logic              dut_rst;
  logic [CMD_W-1:0]  cmd;
  logic              cmd_hasAny;
  logic              cmd_consume;
  logic [DATA_W-1:0] in;
  logic              in_isReady;
  logic              in_canReceive;
  logic [DATA_W-1:0] out;
  logic              out_isReady;
  logic              out_canReceive;

  modport master (
    output dut_rst, cmd, cmd_hasAny, in, in_isReady, out_canReceive,
    input  cmd_consume, in_canReceive, out, out_isReady
  );

  modport slave (
    input  dut_rst, cmd, cmd_hasAny, in, in_isReady, out_canReceive,
    output cmd_consume, in_canReceive, out, out_isReady
  );
endinterface

// File: rtl/main_core_selftest_seq_ram.sv
// Script store: DEPTH x WIDTH, one write port, one synchronous read port (1-cycle latency).
module main_core_selftest_seq_ram #(
  parameter int  DEPTH = 256,
  parameter int  WIDTH = 67,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/main_core_selftest_seq.sv
// Scripted driver/checker for the main_core handshake; replays the stored script and latches the first failure.
// Handshake watchdog is built only with SELFTEST_TIMEOUT_EN defined.
// state | meaning
// IDLE  | waiting for start; script writable
// FETCH | script read issued at pc
// EXEC  | executing the entry at pc
module main_core_selftest_seq
  import main_core_selftest_seq_pkg::*;
#(
  parameter int  DATA_W = 64,
  parameter int  CMD_W  = 16,
  parameter int  DEPTH  = 256,
  parameter int  TMO_W  = 16,
  localparam int AW     = $clog2(DEPTH),
  localparam int PW     = pw_of(DATA_W, CMD_W),
  localparam int EW     = OP_W + PW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [1:0]        fail_code,
  output logic [AW-1:0]     fail_pc,
  output logic [DATA_W-1:0] fail_got,
  input  logic              script_we,
  input  logic [AW-1:0]     script_addr,
  input  logic [EW-1:0]     script_wdata,
  main_core_selftest_seq_if.master core
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TMO_W < 1) begin : g_param_check
    $error("main_core_selftest_seq: DEPTH must be a power of two >= 2 and TMO_W >= 1");
  end

  state_e            state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              exec_first_q, exec_first_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic [1:0]        fail_code_q, fail_code_d;
  logic [AW-1:0]     fail_pc_q, fail_pc_d;
  logic [DATA_W-1:0] fail_got_q, fail_got_d;
`ifdef SELFTEST_TIMEOUT_EN
  logic [TMO_W-1:0]  tmo_q, tmo_d;
`endif

  logic [EW-1:0]     entry;
  op_e               op;
  logic [PW-1:0]     payload;
  logic [WAIT_W-1:0] wait_pl;
  logic              step_done;
  logic              is_hs;

  main_core_selftest_seq_ram #(.DEPTH(DEPTH), .WIDTH(EW)) u_ram (
    .clk   (clk),
    .we    (script_we && (state_q == S_IDLE)),
    .waddr (script_addr),
    .wdata (script_wdata),
    .re    (state_q == S_FETCH),
    .raddr (pc_q),
    .rdata (entry)
  );

  always_comb begin
    op      = op_e'(entry[EW-1:PW]);
    payload = entry[PW-1:0];
    wait_pl = payload[WAIT_W-1:0];
    is_hs   = (op == OP_CMD) || (op == OP_SEND) || (op == OP_RECV) || (op == OP_DRAIN);
    case (op)
      OP_CMD:            step_done = core.cmd_consume;
      OP_SEND:           step_done = core.in_canReceive;
      OP_RECV, OP_DRAIN: step_done = core.out_isReady;
      OP_WAIT:           step_done = exec_first_q ? (wait_pl == '0) : (wait_q == '0);
      default:           step_done = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      wait_q       <= '0;
      exec_first_q <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_code_q  <= FC_NONE;
      fail_pc_q    <= '0;
      fail_got_q   <= '0;
`ifdef SELFTEST_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      wait_q       <= wait_d;
      exec_first_q <= exec_first_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      fail_code_q  <= fail_code_d;
      fail_pc_q    <= fail_pc_d;
      fail_got_q   <= fail_got_d;
`ifdef SELFTEST_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    wait_d       = wait_q;
    exec_first_d = (state_q == S_FETCH);
    done_d       = done_q;
    fail_d       = fail_q;
    fail_code_d  = fail_code_q;
    fail_pc_d    = fail_pc_q;
    fail_got_d   = fail_got_q;
`ifdef SELFTEST_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_FETCH;
          pc_d        = '0;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_code_d = FC_NONE;
          fail_pc_d   = '0;
          fail_got_d  = '0;
        end
      end
      S_FETCH: begin
        state_d = S_EXEC;
`ifdef SELFTEST_TIMEOUT_EN
        tmo_d   = '1;
`endif
      end
      S_EXEC: begin
        // WAIT is a down-counter: first EXEC cycle loads payload-1, terminal count at zero
        if (op == OP_WAIT) wait_d = (exec_first_q ? wait_pl : wait_q) - WAIT_W'(1);
        if (op == OP_END || op == OP_RSVD) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (step_done) begin
          if (op == OP_RECV && core.out != payload[DATA_W-1:0]) begin
            done_d      = 1'b1;
            fail_d      = 1'b1;
            fail_code_d = FC_MISMATCH;
            fail_pc_d   = pc_q;
            fail_got_d  = core.out;
            state_d     = S_IDLE;
          end else if (pc_q == AW'(DEPTH - 1)) begin
            done_d      = 1'b1;
            fail_d      = 1'b1;
            fail_code_d = FC_OVERRUN;
            fail_pc_d   = pc_q;
            state_d     = S_IDLE;
          end else begin
            pc_d    = pc_q + AW'(1);
            state_d = S_FETCH;
          end
        end
`ifdef SELFTEST_TIMEOUT_EN
        else if (is_hs) begin
          if (tmo_q == TMO_W'(1)) begin
            done_d      = 1'b1;
            fail_d      = 1'b1;
            fail_code_d = FC_TIMEOUT;
            fail_pc_d   = pc_q;
            state_d     = S_IDLE;
          end else begin
            tmo_d = tmo_q - TMO_W'(1);
          end
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy                = (state_q != S_IDLE);
    core.dut_rst        = 1'b0;
    core.cmd            = '0;
    core.cmd_hasAny     = 1'b0;
    core.in             = '0;
    core.in_isReady     = 1'b0;
    core.out_canReceive = 1'b0;
    if (state_q == S_EXEC && is_hs | (op == OP_RST)) begin
      case (op)
        OP_CMD: begin
          core.cmd        = payload[CMD_W-1:0];
          core.cmd_hasAny = 1'b1;
        end
        OP_SEND: begin
          core.in         = payload[DATA_W-1:0];
          core.in_isReady = 1'b1;
        end
        OP_RECV, OP_DRAIN: core.out_canReceive = 1'b1;
        OP_RST:            core.dut_rst        = 1'b1;
        default: ;
      endcase
    end
  end

  assign done      = done_q;
  assign fail      = fail_q;
  assign fail_code = fail_code_q;
  assign fail_pc   = fail_pc_q;
  assign fail_got  = fail_got_q;
endmodule

// File: tb/tb_main_core_selftest_seq.sv
// Bench for main_core_selftest_seq: loopback core stub, table of short scripts, plus multi-cycle corner sequences.
module tb_main_core_selftest_seq;
  import main_core_selftest_seq_pkg::*;

  localparam int DATA_W = 64;
  localparam int CMD_W  = 16;
  localparam int DEPTH  = 8;
  localparam int TMO_W  = 4;
  localparam int AW     = 3;
  localparam int PW     = 64;
  localparam int EW     = 67;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              script_we = 1'b0;
  logic [AW-1:0]     script_addr = '0;
  logic [EW-1:0]     script_wdata = '0;
  logic              busy, done, fail;
  logic [1:0]        fail_code;
  logic [AW-1:0]     fail_pc;
  logic [DATA_W-1:0] fail_got;

  logic              in_cr_en = 1'b1;
  logic              out_rdy_en = 1'b1;
  logic [DATA_W-1:0] last_in_q = '0;
  logic              have_q = 1'b0;
  int                n_cmd = 0, n_in = 0, n_rst = 0, onehot_bad = 0;
  int                checks = 0, errors = 0;

  main_core_selftest_seq_if #(.DATA_W(DATA_W), .CMD_W(CMD_W)) bus ();

  main_core_selftest_seq #(.DATA_W(DATA_W), .CMD_W(CMD_W), .DEPTH(DEPTH), .TMO_W(TMO_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .fail_code    (fail_code),
    .fail_pc      (fail_pc),
    .fail_got     (fail_got),
    .script_we    (script_we),
    .script_addr  (script_addr),
    .script_wdata (script_wdata),
    .core         (bus)
  );

  always #5 clk = ~clk;

  // loopback stub: takes every command at once, echoes the last word sent
  assign bus.cmd_consume   = bus.cmd_hasAny;
  assign bus.in_canReceive = in_cr_en;
  assign bus.out           = last_in_q;
  assign bus.out_isReady   = have_q & out_rdy_en;

  always @(posedge clk) begin
    if (bus.in_isReady && bus.in_canReceive) begin
      last_in_q <= bus.in;
      have_q    <= 1'b1;
      n_in      <= n_in + 1;
    end else if (bus.out_isReady && bus.out_canReceive) begin
      have_q <= 1'b0;
    end
    if (bus.cmd_hasAny && bus.cmd_consume) n_cmd <= n_cmd + 1;
    if (bus.dut_rst) n_rst <= n_rst + 1;
  end

  always @(negedge clk) begin
    if (int'(bus.cmd_hasAny) + int'(bus.in_isReady) + int'(bus.out_canReceive) > 1)
      onehot_bad <= onehot_bad + 1;
  end

  typedef struct packed {
    logic [3:0][2:0]  ops;
    logic [3:0][63:0] pls;
    logic             exp_fail;
    logic [1:0]       exp_code;
    logic [2:0]       exp_pc;
    logic [63:0]      exp_got;
    logic [3:0]       exp_ncmd;
    logic [3:0]       exp_nin;
    logic [3:0]       exp_nrst;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] o0, input logic [63:0] p0,
                              input logic [2:0] o1, input logic [63:0] p1,
                              input logic [2:0] o2, input logic [63:0] p2,
                              input logic [2:0] o3, input logic [63:0] p3,
                              input logic f, input logic [1:0] c, input logic [2:0] pc,
                              input logic [63:0] got, input logic [3:0] nc,
                              input logic [3:0] ni, input logic [3:0] nr);
    vec_t v;
    v.ops[0] = o0; v.pls[0] = p0;
    v.ops[1] = o1; v.pls[1] = p1;
    v.ops[2] = o2; v.pls[2] = p2;
    v.ops[3] = o3; v.pls[3] = p3;
    v.exp_fail = f; v.exp_code = c; v.exp_pc = pc; v.exp_got = got;
    v.exp_ncmd = nc; v.exp_nin = ni; v.exp_nrst = nr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [2:0] op, input logic [63:0] pl);
    @(negedge clk);
    script_we    = 1'b1;
    script_addr  = addr;
    script_wdata = {op, pl};
    @(negedge clk);
    script_we    = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: done not seen within 400 cycles", name);
    end
  endtask

  task automatic wait_in_ready(input string name);
    int n = 0;
    while (!bus.in_isReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.in_isReady) begin
      errors++;
      $display("FAIL %s: in_isReady not seen within 50 cycles", name);
    end
  endtask

  vec_t vecs[6];
  int   c0, i0, r0, first_rst, rst_cnt, cr_cycles;

  initial begin
    vecs[0] = mk(OP_CMD, 64'h12, OP_SEND, 64'hA5A5_A5A5_A5A5_A5A5, OP_RECV, 64'hA5A5_A5A5_A5A5_A5A5,
                 OP_END, 64'h0, 1'b0, 2'd0, 3'd0, 64'h0, 4'd1, 4'd1, 4'd0);
    vecs[1] = mk(OP_SEND, 64'h2, OP_CMD, 64'h3, OP_RECV, 64'h1, OP_END, 64'h0,
                 1'b1, 2'd1, 3'd2, 64'h2, 4'd1, 4'd1, 4'd0);
    vecs[2] = mk(OP_SEND, 64'h7, OP_DRAIN, 64'h0, OP_WAIT, 64'h2, OP_END, 64'h0,
                 1'b0, 2'd0, 3'd0, 64'h0, 4'd0, 4'd1, 4'd0);
    vecs[3] = mk(OP_RSVD, 64'h0, OP_CMD, 64'h5, OP_CMD, 64'h5, OP_CMD, 64'h5,
                 1'b0, 2'd0, 3'd0, 64'h0, 4'd0, 4'd0, 4'd0);
    vecs[4] = mk(OP_CMD, 64'hBEEF, OP_WAIT, 64'h0, OP_RST, 64'h0, OP_END, 64'h0,
                 1'b0, 2'd0, 3'd0, 64'h0, 4'd1, 4'd0, 4'd1);
    vecs[5] = mk(OP_SEND, 64'h0123_4567_89AB_CDEF, OP_RECV, 64'h0123_4567_89AB_CDEE, OP_END, 64'h0,
                 OP_END, 64'h0, 1'b1, 2'd1, 3'd1, 64'h0123_4567_89AB_CDEF, 4'd0, 4'd1, 4'd0);

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_fail", 64'(fail), 64'(0));
    chk("rst_fail_code", 64'(fail_code), 64'(0));
    chk("rst_fail_pc", 64'(fail_pc), 64'(0));
    chk("rst_fail_got", fail_got, 64'(0));
    chk("rst_cmd_hasAny", 64'(bus.cmd_hasAny), 64'(0));
    chk("rst_in_isReady", 64'(bus.in_isReady), 64'(0));
    chk("rst_out_canReceive", 64'(bus.out_canReceive), 64'(0));
    chk("rst_dut_rst", 64'(bus.dut_rst), 64'(0));
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      for (int e = 0; e < 4; e++) wr(AW'(e), vecs[v].ops[e], vecs[v].pls[e]);
      c0 = n_cmd; i0 = n_in; r0 = n_rst;
      pulse_start();
      wait_done($sformatf("v%0d_done", v));
      @(negedge clk);
      chk($sformatf("v%0d_busy", v), 64'(busy), 64'(0));
      chk($sformatf("v%0d_fail", v), 64'(fail), 64'(vecs[v].exp_fail));
      chk($sformatf("v%0d_fail_code", v), 64'(fail_code), 64'(vecs[v].exp_code));
      chk($sformatf("v%0d_fail_pc", v), 64'(fail_pc), 64'(vecs[v].exp_pc));
      chk($sformatf("v%0d_fail_got", v), fail_got, vecs[v].exp_got);
      chk($sformatf("v%0d_n_cmd", v), 64'(n_cmd - c0), 64'(vecs[v].exp_ncmd));
      chk($sformatf("v%0d_n_in", v), 64'(n_in - i0), 64'(vecs[v].exp_nin));
      chk($sformatf("v%0d_n_rst", v), 64'(n_rst - r0), 64'(vecs[v].exp_nrst));
    end

    // SEND held off for 5 cycles: word and valid must not move
    wr(AW'(0), OP_SEND, 64'h1234_5678_9ABC_DEF0);
    wr(AW'(1), OP_END, 64'h0);
    in_cr_en = 1'b0;
    pulse_start();
    wait_in_ready("stall_ready");
    i0 = n_in;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall_in_%0d", k), bus.in, 64'h1234_5678_9ABC_DEF0);
      chk($sformatf("stall_rdy_%0d", k), 64'(bus.in_isReady), 64'(1));
      @(negedge clk);
    end
    chk("stall_no_xfer", 64'(n_in - i0), 64'(0));
    chk("stall_in_6", bus.in, 64'h1234_5678_9ABC_DEF0);
    in_cr_en = 1'b1;
    @(negedge clk);
    chk("stall_xfer", 64'(n_in - i0), 64'(1));
    chk("stall_rdy_drop", 64'(bus.in_isReady), 64'(0));
    chk("stall_in_zero", bus.in, 64'(0));
    wait_done("stall_done");
    chk("stall_fail", 64'(fail), 64'(0));

    // WAIT 3 then RST: FETCH, 4 EXEC cycles, FETCH, then the reset pulse
    wr(AW'(0), OP_WAIT, 64'h3);
    wr(AW'(1), OP_RST, 64'h0);
    wr(AW'(2), OP_END, 64'h0);
    pulse_start();
    first_rst = 0; rst_cnt = 0;
    for (int n = 1; n <= 30; n++) begin
      if (bus.dut_rst) begin
        rst_cnt++;
        if (first_rst == 0) first_rst = n;
      end
      @(negedge clk);
    end
    chk("wait_rst_cycle", 64'(first_rst), 64'(7));
    chk("wait_rst_width", 64'(rst_cnt), 64'(1));
    chk("wait_rst_done", 64'(done), 64'(1));
    chk("wait_rst_fail", 64'(fail), 64'(0));

    // no END anywhere: overrun at the last entry
    for (int e = 0; e < DEPTH; e++) wr(AW'(e), OP_WAIT, 64'h0);
    pulse_start();
    wait_done("ovr_done");
    chk("ovr_fail", 64'(fail), 64'(1));
    chk("ovr_fail_code", 64'(fail_code), 64'(3));
    chk("ovr_fail_pc", 64'(fail_pc), 64'(7));

    // reset mid-SEND aborts silently
    wr(AW'(0), OP_SEND, 64'h55);
    wr(AW'(1), OP_END, 64'h0);
    in_cr_en = 1'b0;
    pulse_start();
    wait_in_ready("abort_ready");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_in_isReady", 64'(bus.in_isReady), 64'(0));
    chk("abort_in", bus.in, 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_fail", 64'(fail), 64'(0));

    // rerun from pc 0; a write during the run must be dropped
    i0 = n_in;
    pulse_start();
    wait_in_ready("rerun_ready");
    wr(AW'(1), OP_RECV, 64'hDEAD);
    in_cr_en = 1'b1;
    wait_done("rerun_done");
    chk("rerun_fail", 64'(fail), 64'(0));
    chk("rerun_fail_code", 64'(fail_code), 64'(0));
    chk("rerun_n_in", 64'(n_in - i0), 64'(1));

    // write and start together: the run sees the new entry
    wr(AW'(0), OP_SEND, 64'h77);
    in_cr_en = 1'b0;
    i0 = n_in;
    @(negedge clk);
    script_we    = 1'b1;
    script_addr  = AW'(0);
    script_wdata = {OP_END, 64'h0};
    start        = 1'b1;
    @(negedge clk);
    script_we = 1'b0;
    start     = 1'b0;
    wait_done("wrstart_done");
    chk("wrstart_busy", 64'(busy), 64'(0));
    chk("wrstart_no_send", 64'(n_in - i0), 64'(0));
    chk("wrstart_fail", 64'(fail), 64'(0));
    in_cr_en = 1'b1;

`ifdef SELFTEST_TIMEOUT_EN
    wr(AW'(0), OP_SEND, 64'h9);
    wr(AW'(1), OP_RECV, 64'h9);
    wr(AW'(2), OP_END, 64'h0);
    out_rdy_en = 1'b0;
    pulse_start();
    cr_cycles = 0;
    for (int n = 0; n < 60 && !done; n++) begin
      if (bus.out_canReceive) cr_cycles++;
      @(negedge clk);
    end
    chk("tmo_done", 64'(done), 64'(1));
    chk("tmo_cycles", 64'(cr_cycles), 64'(15));
    chk("tmo_fail_code", 64'(fail_code), 64'(2));
    chk("tmo_fail_pc", 64'(fail_pc), 64'(1));
    chk("tmo_out_canReceive", 64'(bus.out_canReceive), 64'(0));
    out_rdy_en = 1'b1;
`endif

    chk("onehot_handshake", 64'(onehot_bad), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
